// File: rtl/rf_multiport.sv
// rf_multiport: parametrised register file, N async read ports, 1 sync write.
// Optional same-cycle write-to-read forwarding under `define RF_BYPASS_EN.
module rf_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rst,
  input  logic                     clr,
  output logic                     busy,
  input  logic [NUM_RD*ADDR_W-1:0] rR,
  output logic [NUM_RD*DATA_W-1:0] rD,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wR,
  input  logic [DATA_W-1:0]        wD,
  output logic                     wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  // entry 0 is a silent no-op target when hardwired to zero
  assign wr_ok = we && !((ZERO_REG != 0) && (wR == '0));
  assign busy  = (state == CLEAR);

  // clear engine: walks the pointer once over the array, then idles
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state   <= CLEAR;
      clr_ptr <= PTR_FIRST;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= (state == CLEAR) && wr_ok;
      unique case (state)
        IDLE: begin
          if (clr) begin
            state   <= CLEAR;
            clr_ptr <= PTR_FIRST;
          end
        end
        CLEAR: begin
          if (clr_ptr == PTR_LAST)
            state <= IDLE;
          clr_ptr <= clr_ptr + ADDR_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // single write path: clear zeroes take precedence over user writes
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wR;
    mem_wd = wD;
    if (!cpu_rst) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
        mem_wa = clr_ptr;
        mem_wd = '0;
      end else if (wr_ok) begin
        mem_we = 1'b1;
      end
    end
  end

  // storage has no reset so it can live in distributed RAM
  always_ff @(posedge cpu_clk) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              zr_hit;
    assign ra     = rR[g*ADDR_W +: ADDR_W];
    assign zr_hit = (ZERO_REG != 0) && (ra == '0);
`ifdef RF_BYPASS_EN
    logic fwd;
    assign fwd = (state == IDLE) && wr_ok && (ra == wR);
    assign rD[g*DATA_W +: DATA_W] =
      (busy || zr_hit) ? '0 :
      fwd              ? wD :
                         mem[ra];
`else
    assign rD[g*DATA_W +: DATA_W] =
      (busy || zr_hit) ? '0 : mem[ra];
`endif
  end

endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: two configurations (zero-reg 3-port, plain 2-port)
// driven in lockstep and checked against an array-level model.
module tb_rf_multiport;

  logic        clk = 1'b0;
  logic        cpu_rst, clr, we;
  logic [4:0]  wR;
  logic [31:0] wD;
  logic [14:0] rRA;
  logic [95:0] rDA;
  logic [9:0]  rRB;
  logic [63:0] rDB;
  logic        busyA, busyB, dropA, dropB;

  always #5 clk = ~clk;

  rf_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(1)) dut_a (
    .cpu_clk(clk), .cpu_rst(cpu_rst), .clr(clr), .busy(busyA),
    .rR(rRA), .rD(rDA), .we(we), .wR(wR), .wD(wD), .wr_drop(dropA)
  );

  rf_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) dut_b (
    .cpu_clk(clk), .cpu_rst(cpu_rst), .clr(clr), .busy(busyB),
    .rR(rRB), .rD(rDB), .we(we), .wR(wR), .wD(wD), .wr_drop(dropB)
  );

  int tests = 0;
  int fails = 0;

  logic        n_rst = 0, n_clr = 0, n_we = 0;
  logic [4:0]  n_wR = 0;
  logic [31:0] n_wD = 0;
  logic [14:0] n_rRA = 0;
  logic [9:0]  n_rRB = 0;

  logic [95:0] s_rdA;
  logic [63:0] s_rdB;
  logic        s_busyA, s_busyB, s_dropA, s_dropB;

  logic [31:0] memA [32];
  logic [31:0] memB [32];
  int          remA = 0, remB = 0;
  bit          mdropA = 0, mdropB = 0;
  bit          mvalid = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] erd(input bit zr, input bit bsy,
                                      input logic [4:0] a,
                                      input logic [31:0] mv);
    if (bsy || (zr && a == 5'd0)) return 32'd0;
`ifdef RF_BYPASS_EN
    if (we && !(zr && wR == 5'd0) && a == wR) return wD;
`endif
    return mv;
  endfunction

  // advance the model by one rising edge for one configuration
  task automatic step(input bit zr, inout int rem, inout bit mdrop,
                      inout logic [31:0] m [32]);
    bit ok;
    ok = we && !(zr && wR == 5'd0);
    if (cpu_rst) begin
      rem   = 32 - int'(zr);
      mdrop = 0;
      for (int i = 0; i < 32; i++) m[i] = 32'd0;
    end else if (rem > 0) begin
      mdrop = ok;
      rem--;
    end else begin
      mdrop = 0;
      if (ok) m[wR] = wD;
      if (clr) begin
        rem = 32 - int'(zr);
        for (int i = 0; i < 32; i++) m[i] = 32'd0;
      end
    end
  endtask

  task automatic cyc();
    logic [4:0] a;
    @(negedge clk);
    cpu_rst = n_rst; clr = n_clr; we = n_we;
    wR = n_wR; wD = n_wD; rRA = n_rRA; rRB = n_rRB;
    #1;
    s_rdA = rDA; s_rdB = rDB;
    s_busyA = busyA; s_busyB = busyB;
    s_dropA = dropA; s_dropB = dropB;
    if (mvalid) begin
      chk("busyA", {31'd0, busyA}, {31'd0, remA > 0});
      chk("busyB", {31'd0, busyB}, {31'd0, remB > 0});
      chk("dropA", {31'd0, dropA}, {31'd0, mdropA});
      chk("dropB", {31'd0, dropB}, {31'd0, mdropB});
      for (int p = 0; p < 3; p++) begin
        a = rRA[p*5 +: 5];
        chk("rdA", rDA[p*32 +: 32], erd(1, remA > 0, a, memA[a]));
      end
      for (int p = 0; p < 2; p++) begin
        a = rRB[p*5 +: 5];
        chk("rdB", rDB[p*32 +: 32], erd(0, remB > 0, a, memB[a]));
      end
    end
    @(posedge clk);
    step(1, remA, mdropA, memA);
    step(0, remB, mdropB, memB);
    if (cpu_rst) mvalid = 1;
  endtask

  int cntA, cntB;

  task automatic count_busy(input int n);
    cntA = 0; cntB = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (s_busyA) cntA++;
      if (s_busyB) cntB++;
    end
  endtask

  initial begin
    cpu_rst = 1; clr = 0; we = 0; wR = 0; wD = 0; rRA = 0; rRB = 0;

    n_rst = 1;
    cyc();
    n_rst = 0;
    count_busy(40);
    chk("rst_busy_len_zr1", cntA, 31);
    chk("rst_busy_len_zr0", cntB, 32);

    for (int a = 0; a < 32; a++) begin
      n_rRA = {3{a[4:0]}};
      n_rRB = {2{a[4:0]}};
      cyc();
      chk("post_clear_A", s_rdA[63:32], 32'd0);
      chk("post_clear_B", s_rdB[31:0], 32'd0);
    end

    n_we = 1; n_wR = 5; n_wD = 32'hDEADBEEF; n_rRA = 15'd5;
    cyc();
`ifdef RF_BYPASS_EN
    chk("same_cycle_r5", s_rdA[31:0], 32'hDEADBEEF);
`else
    chk("same_cycle_r5", s_rdA[31:0], 32'd0);
`endif
    n_we = 0;
    cyc();
    chk("next_cycle_r5", s_rdA[31:0], 32'hDEADBEEF);

    n_we = 1; n_wR = 0; n_wD = 32'h12345678;
    cyc();
    n_we = 0; n_rRA = 15'd0; n_rRB = 10'd0;
    cyc();
    chk("r0_zero_reg", s_rdA[31:0], 32'd0);
    chk("r0_no_drop", {31'd0, s_dropA}, 32'd0);
    chk("r0_plain", s_rdB[31:0], 32'h12345678);

    for (int i = 1; i < 32; i++) begin
      n_we = 1; n_wR = 5'(i); n_wD = i;
      cyc();
    end
    n_wR = 3; n_wD = 32'hA5A5A5A5;
    cyc();
    n_we = 0; n_rRA = {5'd0, 5'd3, 5'd3};
    cyc();
    chk("3port_p0", s_rdA[31:0], 32'hA5A5A5A5);
    chk("3port_p1", s_rdA[63:32], 32'hA5A5A5A5);
    chk("3port_p2", s_rdA[95:64], 32'd0);
    n_rRB = {5'd9, 5'd31};
    cyc();
    chk("fill_r31", s_rdB[31:0], 32'd31);
    chk("fill_r9", s_rdB[63:32], 32'd9);

    n_clr = 1;
    cyc();
    n_clr = 0;
    cntA = 0;
    for (int i = 0; i < 40; i++) begin
      n_we = (i == 4); n_wR = 7; n_wD = 32'h77;
      cyc();
      if (s_busyA) cntA++;
      if (i == 5) chk("drop_pulse", {31'd0, s_dropA}, 32'd1);
      if (i == 6) chk("drop_one_cycle", {31'd0, s_dropA}, 32'd0);
    end
    chk("clr_busy_len", cntA, 31);
    n_we = 0; n_rRA = 15'd7;
    cyc();
    chk("r7_cleared", s_rdA[31:0], 32'd0);

    n_clr = 1;
    cyc();
    n_clr = 0;
    for (int i = 0; i < 10; i++) cyc();
    n_rst = 1;
    cyc();
    n_rst = 0;
    count_busy(40);
    chk("midclr_rst_zr1", cntA, 31);
    chk("midclr_rst_zr0", cntB, 32);

    for (int i = 0; i < 2000; i++) begin
      n_rst = ($urandom_range(0, 499) == 0);
      n_clr = ($urandom_range(0, 59) == 0);
      n_we  = $urandom_range(0, 1) == 1;
      n_wR  = 5'($urandom);
      n_wD  = $urandom;
      for (int p = 0; p < 3; p++)
        n_rRA[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? n_wR : 5'($urandom);
      for (int p = 0; p < 2; p++)
        n_rRB[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? n_wR : 5'($urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
- Parametrised successor to the CPU general-purpose register file.
- Configurable data width, depth and number of asynchronous read ports; one synchronous write port.
- Storage is cleared by an internal sequential clear engine, one entry per cycle, so it maps onto distributed RAM instead of a flop array with a flat reset.
- Sits between decode (read ports) and writeback (write port) in the pipelined core.

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 hardwired to zero and never written; 0 = entry 0 is an ordinary register

Ports:
cpu_clk  input  1  clock; all state changes on rising edge
cpu_rst  input  1  synchronous active-high reset
clr  input  1  request full clear of storage (pulse, one cycle)
busy  output  1  high while clear engine is running
rR  input  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
rD  output  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W]
we  input  1  write enable
wR  input  ADDR_W  write address
wD  input  DATA_W  write data
wr_drop  output  1  registered; pulses high one cycle after a write was discarded

Behaviour:
- Clock/reset: cpu_clk is the only clock. cpu_rst is synchronous and active-high.
- Storage: DEPTH x DATA_W array. The array itself has no reset term and exactly one write path per cycle.
- FSM states: IDLE, CLEAR.
- On cpu_rst:
  - state <= CLEAR, clr_ptr <= ZERO_REG ? 1 : 0, wr_drop <= 0.
  - busy is 1 from the first cycle after reset.
  - cpu_rst has priority over everything, including a clear in progress. A reset mid-clear restarts the pointer.
- CLEAR:
  - Each cycle writes 0 to mem[clr_ptr], then clr_ptr++.
  - When clr_ptr == DEPTH-1 is written: state <= IDLE, busy <= 0 the following cycle.
  - Duration: DEPTH-ZERO_REG cycles (31 for the defaults).
  - clr asserted during CLEAR is ignored; no restart.
- IDLE:
  - clr=1 → state <= CLEAR and clr_ptr reloads as on reset. busy rises next cycle.
  - clr and a valid write in the same cycle: the write is performed and the clear starts next cycle, which then zeroes that entry as well.
- Write (registered): in IDLE, if we=1 and !(ZERO_REG && wR==0), then mem[wR] <= wD at the rising edge.
- wr_drop:
  - Set to 1 for one cycle when we=1 while state==CLEAR.
  - wR==0 with ZERO_REG=1 is a legal no-op, not a drop.
  - wr_drop is 0 in every other case, including after reset.
- Reads (combinational, independent per port):
  - rD[i] = 0 if ZERO_REG && rR[i]==0.
  - rD[i] = 0 while busy (storage contents undefined until clear completes).
  - Otherwise rD[i] = mem[rR[i]].
  - Any number of ports may read the same address.
- Read/write same address same cycle: without bypass, the read returns the old value; the new value is visible the next cycle.
- Output reset values: busy=1 (from the cycle after cpu_rst is sampled), wr_drop=0, all rD=0.
- No X propagation: after the clear completes, every entry reads a defined value.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-to-read forwarding. If we=1, state==IDLE, the write is valid (not the ZERO_REG entry 0), and rR[i]==wR, then rD[i] = wD combinationally in the same cycle.
- Not defined: no forwarding; same-cycle read returns the pre-write value. The zero-register and busy rules apply identically in both builds.

Test Plan:
- Reset release → busy=1 for exactly 31 cycles (defaults), then 0. Every address reads 0x00000000 on both ports.
- Idle: write we=1, wR=5, wD=0xDEADBEEF → next cycle rR0=5 gives 0xDEADBEEF. The same-cycle read gives 0 without RF_BYPASS_EN and 0xDEADBEEF with it.
- Write wR=0, wD=0x12345678 with ZERO_REG=1 → rD for address 0 stays 0 and wr_drop stays 0. With ZERO_REG=0 the entry reads 0x12345678 and clear takes 32 cycles.
- Fill r1..r31 with their index; pulse clr → busy high 31 cycles. A write we=1, wR=7 during the clear gives wr_drop=1 the next cycle. After busy falls, r7 reads 0.
- Assert cpu_rst at cycle 10 of a clear → pointer restarts; busy stays high a further 31 cycles after reset release.
- NUM_RD=3: rR={3,3,0} after writing r3=0xA5A5A5A5 → rD ports = {0xA5A5A5A5, 0xA5A5A5A5, 0}.
